// File: rtl/ysyx_22040632_div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_22040632_RISCV_PKG
// Brief   : Shared types and constants for the multi-cycle divide controller.
// Revision: 1.0 - initial release
// ============================================================================
package ysyx_22040632_RISCV_PKG;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  localparam int DIV_ITER_W = 32;
  localparam int DIV_ITER_D = 64;
  localparam int DIV_CNT_W  = 7;

endpackage
`default_nettype wire

// File: rtl/ysyx_22040632_div_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_22040632_divif
// Brief   : Execute-unit <-> divider request/result handshake bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface ysyx_22040632_divif #(
  parameter int XLEN = 64
);
  logic            div_valid;
  logic            div_signed;
  logic            divw;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            flush;
  logic            out_ready;
  logic            div_ready;
  logic            out_valid;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  modport master (
    output div_valid, div_signed, divw, dividend, divisor, flush, out_ready,
    input  div_ready, out_valid, quotient, remainder
  );

  modport slave (
    input  div_valid, div_signed, divw, dividend, divisor, flush, out_ready,
    output div_ready, out_valid, quotient, remainder
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_22040632_div_ctrl_step.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_22040632_div_step
// Brief   : One restoring-division step: shift, trial subtract, set quotient LSB.
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_22040632_div_step #(
  parameter int XLEN = 64
) (
  input  wire logic [XLEN:0]   i_rem,
  input  wire logic [XLEN-1:0] i_quo,
  input  wire logic [XLEN-1:0] i_dvs,
  output logic      [XLEN:0]   o_rem,
  output logic      [XLEN-1:0] o_quo
);

  logic [XLEN+1:0] w_shift;
  logic [XLEN+1:0] w_diff;
  logic            w_ge;

  // One guard bit above the partial remainder keeps the borrow visible.
  assign w_shift = {i_rem, i_quo[XLEN-1]};
  assign w_diff  = w_shift - {2'b00, i_dvs};
  assign w_ge    = ~w_diff[XLEN+1];
  assign o_rem   = w_ge ? w_diff[XLEN:0] : w_shift[XLEN:0];
  assign o_quo   = {i_quo[XLEN-2:0], w_ge};

endmodule
`default_nettype wire

// File: rtl/ysyx_22040632_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_22040632_div_ctrl
// Brief   : RV64 multi-cycle divide controller with RISC-V special-case rules.
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_22040632_div_ctrl
  import ysyx_22040632_RISCV_PKG::*;
#(
  parameter int XLEN = 64
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  ysyx_22040632_divif.slave       dif
);

  localparam int HW = XLEN / 2;

  div_state_e             r_state, w_state_next;
  logic [DIV_CNT_W-1:0]   r_cnt;
  logic [XLEN:0]          r_rem;
  logic [XLEN-1:0]        r_quo, r_dvs;
  logic                   r_q_neg, r_r_neg, r_word;
  logic [XLEN-1:0]        r_res_q, r_res_r;

  logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_sx, w_a_mag, w_b_mag;
  logic            w_a_neg, w_b_neg, w_div_zero, w_ovf, w_accept, w_special;
  logic [XLEN:0]   w_step_rem;
  logic [XLEN-1:0] w_step_quo, w_q_fix, w_r_fix, w_q_res, w_r_res;

  // Operands brought to full width; sign at the active width then sits in the MSB.
  assign w_a_ext = dif.divw ? {{HW{dif.div_signed & dif.dividend[HW-1]}}, dif.dividend[HW-1:0]}
                            : dif.dividend;
  assign w_b_ext = dif.divw ? {{HW{dif.div_signed & dif.divisor[HW-1]}}, dif.divisor[HW-1:0]}
                            : dif.divisor;
  assign w_a_sx  = dif.divw ? {{HW{dif.dividend[HW-1]}}, dif.dividend[HW-1:0]} : dif.dividend;
  assign w_a_neg = dif.div_signed & w_a_ext[XLEN-1];
  assign w_b_neg = dif.div_signed & w_b_ext[XLEN-1];
  assign w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
  assign w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;

  assign w_div_zero = (w_b_ext == '0);
  assign w_ovf      = dif.div_signed && (w_b_ext == '1) &&
                      (dif.divw ? (dif.dividend[HW-1:0] == {1'b1, {(HW-1){1'b0}}})
                                : (dif.dividend == {1'b1, {(XLEN-1){1'b0}}}));
  assign w_special  = w_div_zero | w_ovf;
  assign w_accept   = (r_state == DIV_IDLE) && dif.div_valid && !dif.flush;

  ysyx_22040632_div_step #(.XLEN(XLEN)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_step_rem),
    .o_quo (w_step_quo)
  );

  assign w_q_fix = r_q_neg ? -r_quo : r_quo;
  assign w_r_fix = r_r_neg ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
  assign w_q_res = r_word ? {{HW{w_q_fix[HW-1]}}, w_q_fix[HW-1:0]} : w_q_fix;
  assign w_r_res = r_word ? {{HW{w_r_fix[HW-1]}}, w_r_fix[HW-1:0]} : w_r_fix;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= DIV_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      DIV_IDLE: if (w_accept) w_state_next = w_special ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (r_cnt == DIV_CNT_W'(1)) w_state_next = DIV_FIX;
      DIV_FIX:  w_state_next = DIV_DONE;
      DIV_DONE: if (dif.out_ready) w_state_next = DIV_IDLE;
      default:  w_state_next = DIV_IDLE;
    endcase
    if (dif.flush) w_state_next = DIV_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_word  <= 1'b0;
      r_res_q <= '0;
      r_res_r <= '0;
    end else if (w_accept) begin
      r_word <= dif.divw;
      if (w_div_zero) begin
        r_res_q <= '1;
        r_res_r <= w_a_sx;
      end else if (w_ovf) begin
        r_res_q <= w_a_sx;
        r_res_r <= '0;
      end else begin
        r_q_neg <= w_a_neg ^ w_b_neg;
        r_r_neg <= w_a_neg;
        r_rem   <= '0;
        r_dvs   <= w_b_mag;
        // Word dividends start in the upper half so 32 shifts consume them.
        r_quo   <= dif.divw ? {w_a_mag[HW-1:0], {HW{1'b0}}} : w_a_mag;
        r_cnt   <= dif.divw ? DIV_CNT_W'(DIV_ITER_W) : DIV_CNT_W'(DIV_ITER_D);
      end
    end else if (!dif.flush) begin
      if (r_state == DIV_CALC) begin
        r_rem <= w_step_rem;
        r_quo <= w_step_quo;
        r_cnt <= r_cnt - DIV_CNT_W'(1);
      end else if (r_state == DIV_FIX) begin
        r_res_q <= w_q_res;
        r_res_r <= w_r_res;
      end
    end
  end

  assign dif.div_ready = (r_state == DIV_IDLE);
  assign dif.out_valid = (r_state == DIV_DONE);
  assign dif.quotient  = r_res_q;
  assign dif.remainder = r_res_r;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040632_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_22040632_div_ctrl
// Brief   : Directed self-checking bench for the divide controller.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ysyx_22040632_div_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ysyx_22040632_divif #(.XLEN(64)) dif ();

  ysyx_22040632_div_ctrl #(.XLEN(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dif   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Issue one request and count edges (accept edge = 1) until out_valid.
  task automatic run_op(input logic s, input logic w, input logic [63:0] a,
                        input logic [63:0] b, output int lat);
    @(negedge clk);
    dif.div_valid  = 1'b1;
    dif.div_signed = s;
    dif.divw       = w;
    dif.dividend   = a;
    dif.divisor    = b;
    @(posedge clk); #1;
    dif.div_valid  = 1'b0;
    dif.div_signed = ~s;
    dif.divw       = ~w;
    dif.dividend   = 64'hA5A5_5A5A_0F0F_F0F0;
    dif.divisor    = 64'h3;
    lat = 1;
    while (!dif.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    dif.out_ready = 1'b0;
  endtask

  task automatic chk_result(input string name, input int lat, input int exp_lat,
                            input logic [63:0] eq, input logic [63:0] er);
    total++;
    if (lat !== exp_lat) begin bad++; $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat); end
    total++;
    if (dif.quotient !== eq) begin bad++; $display("FAIL %s quotient: got %h required %h", name, dif.quotient, eq); end
    total++;
    if (dif.remainder !== er) begin bad++; $display("FAIL %s remainder: got %h required %h", name, dif.remainder, er); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (dif.div_ready !== 1'b1) begin bad++; $display("FAIL reset div_ready: got %b required 1", dif.div_ready); end
    total++;
    if (dif.out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b required 0", dif.out_valid); end
    total++;
    if (dif.quotient !== 64'h0) begin bad++; $display("FAIL reset quotient: got %h required 0", dif.quotient); end
    total++;
    if (dif.remainder !== 64'h0) begin bad++; $display("FAIL reset remainder: got %h required 0", dif.remainder); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word_ops();
    int lat;
    run_op(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat);
    chk_result("divw_neg7_by_2", lat, 34, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
    consume();
    run_op(1'b0, 1'b1, 64'hDEAD_BEEF_FFFF_FFFE, 64'hFFFF_0000_0000_0003, lat);
    chk_result("divuw_upper_ignored", lat, 34, 64'h0000_0000_5555_5554, 64'd2);
    consume();
    run_op(1'b0, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, lat);
    chk_result("divuw_result_sext", lat, 34, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0);
    consume();
  endtask

  task automatic test_special();
    int lat;
    run_op(1'b0, 1'b1, 64'h0000_0000_1234_5678, 64'd0, lat);
    chk_result("divuw_by_zero", lat, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_1234_5678);
    consume();
    run_op(1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, lat);
    chk_result("divw_overflow", lat, 1, 64'hFFFF_FFFF_8000_0000, 64'd0);
    consume();
    run_op(1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    chk_result("div64_overflow", lat, 1, 64'h8000_0000_0000_0000, 64'd0);
    consume();
  endtask

  task automatic test_dword_ops();
    int lat;
    run_op(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, lat);
    chk_result("divu64", lat, 66, 64'h0FFF_FFFF_FFFF_FFFF, 64'hF);
    consume();
    run_op(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, lat);
    chk_result("div64_neg100_by_7", lat, 66, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE);
    consume();
  endtask

  task automatic test_flush();
    int lat;
    int rises;
    @(negedge clk);
    dif.div_valid = 1'b1; dif.div_signed = 1'b0; dif.divw = 1'b0;
    dif.dividend = 64'd1000; dif.divisor = 64'd3;
    @(posedge clk); #1;
    dif.div_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    dif.flush = 1'b1;
    @(posedge clk); #1;
    dif.flush = 1'b0;
    total++;
    if (dif.div_ready !== 1'b1) begin bad++; $display("FAIL flush div_ready: got %b required 1", dif.div_ready); end
    rises = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (dif.out_valid) rises++;
    end
    total++;
    if (rises !== 0) begin bad++; $display("FAIL flush out_valid_rose: got %0d cycles required 0", rises); end
    run_op(1'b0, 1'b1, 64'd100, 64'd7, lat);
    chk_result("after_flush_100_by_7", lat, 34, 64'd14, 64'd2);
  endtask

  task automatic test_backpressure();
    logic [63:0] q0, r0;
    q0 = 64'd14; r0 = 64'd2;
    @(negedge clk);
    dif.div_valid = 1'b1; dif.dividend = 64'd55; dif.divisor = 64'd0; dif.divw = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      total++;
      if (dif.quotient !== q0 || dif.remainder !== r0)
        begin bad++; $display("FAIL hold results: got %h/%h required %h/%h", dif.quotient, dif.remainder, q0, r0); end
      total++;
      if (dif.div_ready !== 1'b0 || dif.out_valid !== 1'b1)
        begin bad++; $display("FAIL hold ready/valid: got %b/%b required 0/1", dif.div_ready, dif.out_valid); end
    end
    dif.div_valid = 1'b0;
    consume();
    total++;
    if (dif.div_ready !== 1'b1 || dif.out_valid !== 1'b0)
      begin bad++; $display("FAIL after consume ready/valid: got %b/%b required 1/0", dif.div_ready, dif.out_valid); end
  endtask

  task automatic test_flush_in_done();
    int lat;
    run_op(1'b0, 1'b1, 64'd9, 64'd0, lat);
    @(negedge clk);
    dif.flush = 1'b1; dif.out_ready = 1'b1;
    @(posedge clk); #1;
    dif.flush = 1'b0; dif.out_ready = 1'b0;
    total++;
    if (dif.out_valid !== 1'b0 || dif.div_ready !== 1'b1)
      begin bad++; $display("FAIL flush_done valid/ready: got %b/%b required 0/1", dif.out_valid, dif.div_ready); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    dif.div_valid = 1'b1; dif.div_signed = 1'b0; dif.divw = 1'b0;
    dif.dividend = 64'd77; dif.divisor = 64'd5;
    @(posedge clk); #1;
    dif.div_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if (dif.div_ready !== 1'b1 || dif.out_valid !== 1'b0)
      begin bad++; $display("FAIL reset_mid ready/valid: got %b/%b required 1/0", dif.div_ready, dif.out_valid); end
    total++;
    if (dif.quotient !== 64'h0 || dif.remainder !== 64'h0)
      begin bad++; $display("FAIL reset_mid results: got %h/%h required 0/0", dif.quotient, dif.remainder); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    dif.div_valid  = 1'b0;
    dif.div_signed = 1'b0;
    dif.divw       = 1'b0;
    dif.dividend   = '0;
    dif.divisor    = '0;
    dif.flush      = 1'b0;
    dif.out_ready  = 1'b0;
    test_reset();
    test_word_ops();
    test_special();
    test_dword_ops();
    test_flush();
    test_backpressure();
    test_flush_in_done();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
